// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master word-memory arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS     = 2;
  localparam int TIMEOUT_DEFAULT = 16;

  // One access moves through these phases in order, then returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker. The grant index is combinational. The
// last-served pointer advances only when the caller commits a grant.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   update,
  output logic                   grant
);

  logic last_q, last_d;

  // If both masters request, pick the one not served last. A lone requester always wins.
  always_comb begin
    grant  = ~last_q;
    if (req == 2'b01)      grant = 1'b0;
    else if (req == 2'b10) grant = 1'b1;
    last_d = last_q;
    if (update) last_d = grant;
  end

  // On reset, point at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one shared word memory. Each access runs
// IDLE -> SETUP -> STROBE -> RELEASE. Strobes are registered and stay low
// for at least two cycles between accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [17:0] m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m0_uds,
  input  logic        m0_lds,
  input  logic        m0_rw,
  output logic [15:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_uds,
  input  logic        m1_lds,
  input  logic        m1_rw,
  output logic [15:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_uds,
  output logic        mem_lds,
  output logic        mem_rw,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  state_e                             state_q, state_d;
  logic                               gnt_q, gnt_d;
  logic                               uds_l_q, uds_l_d, lds_l_q, lds_l_d;
  logic [7:0]                         cnt_q, cnt_d;
  logic [17:0]                        mem_addr_q, mem_addr_d;
  logic [15:0]                        mem_wdata_q, mem_wdata_d;
  logic                               mem_uds_q, mem_uds_d, mem_lds_q, mem_lds_d;
  logic                               mem_rw_q, mem_rw_d;
  logic [NUM_MASTERS-1:0]             ack_q, ack_d, err_q, err_d;
  logic [NUM_MASTERS-1:0][15:0]       rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   rr_update, rr_gnt;

  assign req       = {m1_req, m0_req};
  assign rr_update = (state_q == ST_IDLE) && (|req);

  mem_arb_rr u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (rr_update),
    .grant  (rr_gnt)
  );

  // Next-state and register updates. Completion pulses default low, so each pulse lasts one cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    uds_l_d     = uds_l_q;
    lds_l_d     = lds_l_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_uds_d   = mem_uds_q;
    mem_lds_d   = mem_lds_q;
    mem_rw_d    = mem_rw_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    err_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d       = rr_gnt;
          mem_addr_d  = rr_gnt ? m1_addr  : m0_addr;
          mem_wdata_d = rr_gnt ? m1_wdata : m0_wdata;
          mem_rw_d    = rr_gnt ? m1_rw    : m0_rw;
          uds_l_d     = rr_gnt ? m1_uds   : m0_uds;
          lds_l_d     = rr_gnt ? m1_lds   : m0_lds;
          mem_uds_d   = 1'b0;
          mem_lds_d   = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d     = '0;
        mem_uds_d = uds_l_q;
        mem_lds_d = lds_l_q;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
        if (mem_ack) begin
          if (mem_rw_q) rdata_d[gnt_q] = mem_rdata;
          ack_d[gnt_q] = 1'b1;
          mem_uds_d    = 1'b0;
          mem_lds_d    = 1'b0;
          state_d      = ST_RELEASE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d[gnt_q] = 1'b1;
          mem_uds_d    = 1'b0;
          mem_lds_d    = 1'b0;
          state_d      = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers. A synchronous reset drops the strobes and discards any completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      uds_l_q     <= 1'b0;
      lds_l_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_uds_q   <= 1'b0;
      mem_lds_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      uds_l_q     <= uds_l_d;
      lds_l_q     <= lds_l_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_uds_q   <= mem_uds_d;
      mem_lds_q   <= mem_lds_d;
      mem_rw_q    <= mem_rw_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_uds   = mem_uds_q;
  assign mem_lds   = mem_lds_q;
  assign mem_rw    = mem_rw_q;
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table, hand-written corner
// sequences, then random traffic from both masters checked against a
// transaction-level model.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        t_req [2];
  logic [17:0] t_addr[2];
  logic [15:0] t_wd  [2];
  logic        t_uds [2];
  logic        t_lds [2];
  logic        t_rw  [2];

  logic        m0_req, m1_req, m0_uds, m1_uds, m0_lds, m1_lds, m0_rw, m1_rw;
  logic [17:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_uds, mem_lds, mem_rw, mem_ack;

  assign m0_req = t_req[0];  assign m1_req = t_req[1];
  assign m0_addr = t_addr[0]; assign m1_addr = t_addr[1];
  assign m0_wdata = t_wd[0];  assign m1_wdata = t_wd[1];
  assign m0_uds = t_uds[0];   assign m1_uds = t_uds[1];
  assign m0_lds = t_lds[0];   assign m1_lds = t_lds[1];
  assign m0_rw = t_rw[0];     assign m1_rw = t_rw[1];

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_uds(m0_uds),
    .m0_lds(m0_lds), .m0_rw(m0_rw), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_uds(m1_uds),
    .m1_lds(m1_lds), .m1_rw(m1_rw), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_uds(mem_uds), .mem_lds(mem_lds),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Word memory: acks one cycle after it sees a strobe. Addresses with bit 17 set never ack.
  logic [15:0] mem [0:255];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ack <= 1'b0;
      if ((mem_uds || mem_lds) && !mem_ack && !mem_addr[17]) begin
        mem_ack <= 1'b1;
        if (mem_rw) mem_rdata <= mem[mem_addr[7:0]];
        else begin
          if (mem_uds) mem[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
          if (mem_lds) mem[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ackv(input int m);
    return (m != 0) ? m1_ack : m0_ack;
  endfunction
  function automatic logic errv(input int m);
    return (m != 0) ? m1_err : m0_err;
  endfunction
  function automatic logic [15:0] rdv(input int m);
    return (m != 0) ? m1_rdata : m0_rdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int          m;
    logic        rw;
    logic [17:0] addr;
    logic [15:0] wd;
    logic        uds;
    logic        lds;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[10];

  // Drive one lone access, follow it cycle by cycle, and check timing, result and read data.
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  done;
    bit  other;
    int  o;
    o = 1 - v.m;
    done = 0; other = 0;
    t_addr[v.m] = v.addr; t_wd[v.m] = v.wd; t_uds[v.m] = v.uds;
    t_lds[v.m] = v.lds; t_rw[v.m] = v.rw; t_req[v.m] = 1'b1;
    for (n = 1; n <= TO + 8; n++) begin
      tick();
      if (ackv(o) || errv(o)) other = 1;
      if (n == 1) chk($sformatf("v%0d_setup_strobes", idx), {mem_uds, mem_lds}, 2'b00);
      if (n == 2) begin
        chk($sformatf("v%0d_strobe_rise", idx), {mem_uds, mem_lds}, {v.uds, v.lds});
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
      end
      if (ackv(v.m) || errv(v.m)) begin done = 1; break; end
    end
    t_req[v.m] = 1'b0;
    chk($sformatf("v%0d_completed", idx), done, 1);
    chk($sformatf("v%0d_latency", idx), n, v.exp_err ? 2 + TO : 4);
    chk($sformatf("v%0d_ack_err", idx), {ackv(v.m), errv(v.m)}, {!v.exp_err, v.exp_err});
    chk($sformatf("v%0d_rdata", idx), rdv(v.m), v.exp_rd);
    tick();
    chk($sformatf("v%0d_pulse_len", idx), {ackv(v.m), errv(v.m)}, 2'b00);
    chk($sformatf("v%0d_other_quiet", idx), other, 0);
  endtask

  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_rd  [2];
  int  pend[2], since[2], gap[2];
  int  prev_served;

  initial begin
    int  comp_m[$];
    int  comp_t[$];
    logic [15:0] comp_d[$];
    int  s;
    bit  flag;

    tbl[0] = '{0, 1'b0, 18'h00010, 16'hA55A, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{0, 1'b1, 18'h00010, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA55A};
    tbl[2] = '{1, 1'b0, 18'h00020, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{1, 1'b0, 18'h00020, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{1, 1'b1, 18'h00020, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFF34};
    tbl[5] = '{0, 1'b1, 18'h20000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA55A};
    tbl[6] = '{1, 1'b0, 18'h00030, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hFF34};
    tbl[7] = '{1, 1'b1, 18'h00030, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[8] = '{0, 1'b0, 18'h1FFFF, 16'hC3A5, 1'b1, 1'b0, 1'b0, 16'hA55A};
    tbl[9] = '{0, 1'b1, 18'h1FFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hC300};

    for (int m = 0; m < 2; m++) begin
      t_req[m] = 0; t_addr[m] = 0; t_wd[m] = 0; t_uds[m] = 0; t_lds[m] = 0; t_rw[m] = 0;
    end
    reset = 1'b1; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;

    // Reset state
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_ctl", {mem_uds, mem_lds, mem_rw}, 0);
    chk("rst_ack_err", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Reset during STROBE: strobes drop at the reset edge and no completion follows.
    t_addr[1] = 18'h00040; t_wd[1] = 16'h5A5A; t_uds[1] = 1; t_lds[1] = 1; t_rw[1] = 0;
    t_req[1] = 1;
    tick(); tick();
    chk("rs_strobe_high", {mem_uds, mem_lds}, 2'b11);
    reset = 1'b1; t_req[1] = 0;
    tick();
    chk("rs_strobes_low", {mem_uds, mem_lds}, 2'b00);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0;
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      if (m0_ack || m0_err || m1_ack || m1_err) flag = 1;
      tick();
    end
    chk("rs_no_completion", flag, 0);

    // Continuous tie: grants alternate from m0, five cycles apart.
    t_addr[0] = 18'h00010; t_uds[0] = 1; t_lds[0] = 1; t_rw[0] = 1;
    t_addr[1] = 18'h00020; t_uds[1] = 1; t_lds[1] = 1; t_rw[1] = 1;
    t_req[0] = 1; t_req[1] = 1;
    s = cyc;
    for (int n = 0; n < 40 && comp_m.size() < 4; n++) begin
      tick();
      for (int m = 0; m < 2; m++)
        if (ackv(m)) begin comp_m.push_back(m); comp_t.push_back(cyc - s); comp_d.push_back(rdv(m)); end
    end
    t_req[0] = 0; t_req[1] = 0;
    chk("tie_count", comp_m.size(), 4);
    while (comp_m.size() < 4) begin comp_m.push_back(-1); comp_t.push_back(-1); comp_d.push_back('x); end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_master%0d", k), comp_m[k], k % 2);
      chk($sformatf("tie_time%0d", k), comp_t[k], 4 + 5 * k);
      chk($sformatf("tie_rdata%0d", k), comp_d[k], (k % 2) ? 16'hFF34 : 16'hA55A);
    end
    tick();

    // Master changes its fields and drops req after grant; the latched access still completes.
    t_addr[1] = 18'h00050; t_wd[1] = 16'h7777; t_uds[1] = 1; t_lds[1] = 1; t_rw[1] = 0;
    t_req[1] = 1;
    flag = 0;
    s = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) begin t_addr[1] = 18'h00051; t_wd[1] = 16'h1111; end
      if (n == 2) begin
        chk("lat_mem_addr", mem_addr, 18'h00050);
        chk("lat_mem_wdata", mem_wdata, 16'h7777);
        t_req[1] = 0;
      end
      if (m1_ack) begin flag = 1; s = n; break; end
    end
    chk("lat_ack", flag, 1);
    chk("lat_latency", s, 4);
    chk("lat_rdata_kept", m1_rdata, 16'hFF34);
    chk("lat_mem_written", mem[8'h50], 16'h7777);
    chk("lat_mem_other", mem[8'h51], 16'h0000);
    tick();

    // Random traffic against a transaction-level model.
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_rd[0] = 16'hA55A; exp_rd[1] = 16'hFF34;
    prev_served = 1;
    for (int m = 0; m < 2; m++) begin pend[m] = 0; since[m] = 0; gap[m] = 0; end
    for (int it = 0; it < 2400; it++) begin
      int ndone;
      tick();
      ndone = 0;
      for (int m = 0; m < 2; m++) begin
        if (ackv(m) || errv(m)) begin
          int  o, lat, g;
          logic e_err;
          logic [7:0] a;
          ndone++;
          o = 1 - m;
          if (pend[m] == 0) chk("rnd_spurious", 1, 0);
          else begin
            e_err = t_addr[m][17] || !(t_uds[m] || t_lds[m]);
            a = t_addr[m][7:0];
            chk("rnd_result", {ackv(m), errv(m)}, {!e_err, e_err});
            lat = e_err ? 2 + TO : 4;
            g = cyc - lat;
            chk("rnd_after_req", g >= since[m], 1);
            if (pend[o] != 0 && since[o] <= g) chk("rnd_round_robin", prev_served, o);
            if (!e_err && t_rw[m]) exp_rd[m] = ref_mem[a];
            if (!e_err && !t_rw[m]) begin
              if (t_uds[m]) ref_mem[a][15:8] = t_wd[m][15:8];
              if (t_lds[m]) ref_mem[a][7:0]  = t_wd[m][7:0];
            end
            chk("rnd_rdata", rdv(m), exp_rd[m]);
            prev_served = m;
            pend[m] = 0; t_req[m] = 0;
            gap[m] = $urandom_range(0, 3);
          end
        end
      end
      if (ndone > 1) chk("rnd_one_in_flight", ndone, 1);
      for (int m = 0; m < 2; m++) begin
        if (pend[m] == 0) begin
          if (gap[m] > 0) gap[m]--;
          else if (it < 2000) begin
            int r;
            r = $urandom_range(0, 7);
            t_addr[m] = ($urandom_range(0, 7) == 0) ? (18'h20080 | 18'(r)) : (18'h00080 | 18'(r));
            t_wd[m] = 16'($urandom);
            case ($urandom_range(0, 7))
              0:       begin t_uds[m] = 0; t_lds[m] = 0; end
              1, 2:    begin t_uds[m] = 1; t_lds[m] = 0; end
              3, 4:    begin t_uds[m] = 0; t_lds[m] = 1; end
              default: begin t_uds[m] = 1; t_lds[m] = 1; end
            endcase
            t_rw[m] = 1'($urandom_range(0, 1));
            t_req[m] = 1; pend[m] = 1; since[m] = cyc;
          end
        end
      end
    end
    chk("rnd_drained", pend[0] + pend[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 16, STROBE-state cycles without mem_ack before the access is aborted (range 2..255).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mN_req  in  1  (N=0,1) master N requests an access; level, held until mN_ack or mN_err.
REQ-005 mN_addr  in  18  master N word address.
REQ-006 mN_wdata  in  16  master N write data.
REQ-007 mN_uds / mN_lds  in  1 each  master N byte enables, bits 15:8 / 7:0.
REQ-008 mN_rw  in  1  1=read, 0=write.
REQ-009 mN_rdata  out  16  read data; valid in the cycle mN_ack=1.
REQ-010 mN_ack / mN_err  out  1 each  one-cycle completion pulse, success / timeout.
REQ-011 mem_addr, mem_wdata, mem_uds, mem_lds, mem_rw  out  18,16,1,1,1  registered drive to the shared word memory.
REQ-012 mem_rdata  in  16  memory read data; mem_ack  in  1  memory acknowledge.

Function
REQ-013 FSM states IDLE, SETUP, STROBE, RELEASE; exactly one access in flight.
REQ-014 IDLE: when any mN_req=1, select a grantee and latch its addr/wdata/uds/lds/rw into the mem_* registers, strobes held 0; next state SETUP.
REQ-015 Arbitration: round-robin; one requester gets the grant; if both request, the master not served last gets it; last-served pointer updates at each grant.
REQ-016 SETUP: one cycle, mem_uds=mem_lds=0 and address/data stable; next state STROBE.
REQ-017 STROBE: drive latched uds/lds to mem_uds/mem_lds; on a cycle with mem_ack=1, capture mem_rdata into the grantee's rdata register and go to RELEASE with result ack.
REQ-018 STROBE timeout: cycle counter cleared on entry; after TIMEOUT cycles without mem_ack, go to RELEASE with result err.
REQ-019 RELEASE: mem_uds=mem_lds=0; pulse grantee's mN_ack (or mN_err) for exactly this cycle; next state IDLE.
REQ-020 Latency: req sampled in IDLE at cycle c0 -> SETUP c1, strobes rise c2, mem_ack expected c3, mN_ack in c4; back-to-back issue rate one access per 5 cycles.
REQ-021 Strobes are low for at least two cycles (RELEASE, SETUP) between accesses so the memory sees a rising edge on every access.
REQ-022 Latched request fields are immune to master input changes after grant; deasserting mN_req mid-access does not abort; completion pulse is still issued.
REQ-023 Request with uds=lds=0 is executed as normal and ends in mN_err by timeout.
REQ-024 mN_rdata holds its last captured value except when a read completes; write completion leaves it unchanged.
REQ-025 Non-granted master sees mN_ack=mN_err=0 throughout.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, all mem_* outputs 0, mN_ack=mN_err=0, mN_rdata=0, timeout counter 0, last-served pointer = master 1 (master 0 wins first tie).
REQ-027 Reset mid-access drops strobes on the same edge and emits no completion pulse for the aborted access.

Structure
REQ-028 Package mem_arb_pkg holds the FSM state encoding, master count (2) and TIMEOUT default.
REQ-029 Round-robin selection is one sub-module, mem_arb_rr (inputs req[1:0], update strobe; output grant index).

Verification
REQ-030 m0 write addr 0x00010, wdata 0xA55A, uds=lds=1 -> mem strobes rise c2, m0_ack at c4; later m0 read same addr -> m0_rdata=0xA55A with m0_ack.
REQ-031 m1 write lds only, 0x1234 to addr 0x00020 after word preset 0xFFFF -> read back 0xFF34.
REQ-032 m0 and m1 request same cycle continuously -> grants alternate m0,m1,m0,m1; each ack 5 cycles apart.
REQ-033 m0 read addr 0x20000 (no mem_ack) with TIMEOUT=16 -> m0_err pulse after 16 STROBE cycles, no m0_ack, m0_rdata unchanged.
REQ-034 reset asserted in STROBE -> next cycle mem_uds=mem_lds=0, no ack/err, state IDLE; next tie goes to m0.
REQ-035 m1 changes addr/wdata one cycle after grant -> memory receives originally latched values.
